// File: rtl/avg_engine_if.sv
// Sample stream and result bus of the averaging engine.
// The engine connects through the slave modport and the sample source through the master modport.
interface avg_engine_if #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 16,
  parameter int MAX_LOG2 = 16,
  parameter int L_BITS   = 5
);
  logic                               mode_i;
  logic        [L_BITS-1:0]           log2_len_i;
  logic                               clear_i;
  logic signed [IN_BITS-1:0]          in_data;
  logic                               in_valid;
  logic signed [OUT_BITS-1:0]         out_data;
  logic signed [IN_BITS+MAX_LOG2-1:0] sum_o;
  logic                               out_valid;
  logic        [31:0]                 block_cnt_o;

  modport master (
    output mode_i, log2_len_i, clear_i, in_data, in_valid,
    input  out_data, sum_o, out_valid, block_cnt_o
  );

  modport slave (
    input  mode_i, log2_len_i, clear_i, in_data, in_valid,
    output out_data, sum_o, out_valid, block_cnt_o
  );
endinterface

// File: rtl/avg_engine.sv
// Signed sample reducer: decimating boxcar mean or first-order IIR low-pass,
// selected at runtime, with flush and a completed-output counter.
module avg_engine #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 16,
  parameter int MAX_LOG2 = 16,
  parameter int L_BITS   = 5
) (
  input  logic        clk,
  input  logic        aresetn,
  avg_engine_if.slave bus
);
  localparam int ACC_BITS = IN_BITS + MAX_LOG2;
  localparam int CNT_BITS = MAX_LOG2 + 1;

  typedef enum logic {MODE_BOX = 1'b0, MODE_IIR = 1'b1} mode_t;
  typedef logic signed [ACC_BITS-1:0] acc_t;

  mode_t                      mode_q, mode_d;
  logic        [L_BITS-1:0]   l_q, l_d;
  acc_t                       acc_q, acc_d;
  logic        [CNT_BITS-1:0] cnt_q, cnt_d;
  logic signed [OUT_BITS-1:0] out_q, out_d;
  acc_t                       sum_q, sum_d;
  logic                       valid_q, valid_d;
  logic        [31:0]         blk_q, blk_d;

  logic        [L_BITS-1:0]   l_live, l_use;
  logic                       blk_start, box_done;
  acc_t                       x_ext, acc_base, box_sum, x_iir, iir_next;
  logic        [CNT_BITS-1:0] box_cnt;
  logic signed [ACC_BITS:0]   iir_diff;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    mode_d  = mode_q;
    l_d     = l_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    blk_d   = blk_q;

    l_live = (bus.log2_len_i > L_BITS'(MAX_LOG2)) ? L_BITS'(MAX_LOG2) : bus.log2_len_i;

    // Boxcar: an empty counter marks a block start, where the length is latched afresh.
    blk_start = (cnt_q == '0);
    l_use     = blk_start ? l_live : l_q;
    x_ext     = acc_t'(bus.in_data);
    acc_base  = acc_q;
    if (blk_start) acc_base = '0;
    box_sum  = acc_base + x_ext;
    box_cnt  = cnt_q + CNT_BITS'(1);
    box_done = (box_cnt == (CNT_BITS'(1) << l_use));

    // IIR: the difference gets one guard bit, as x - s can span twice the state range.
    x_iir    = x_ext <<< MAX_LOG2;
    iir_diff = {x_iir[ACC_BITS-1], x_iir} - {acc_q[ACC_BITS-1], acc_q};
    iir_next = acc_q + acc_t'(iir_diff >>> l_live);

    if (bus.clear_i || (mode_t'(bus.mode_i) != mode_q)) begin
      mode_d = mode_t'(bus.mode_i);
      acc_d  = '0;
      cnt_d  = '0;
    end else if (bus.in_valid) begin
      if (mode_q == MODE_BOX) begin
        if (box_done) begin
          acc_d   = '0;
          cnt_d   = '0;
          sum_d   = box_sum;
          out_d   = OUT_BITS'(box_sum >>> l_use);
          valid_d = 1'b1;
          blk_d   = blk_q + 32'd1;
        end else begin
          acc_d = box_sum;
          cnt_d = box_cnt;
          l_d   = l_use;
        end
      end else begin
        acc_d   = iir_next;
        out_d   = OUT_BITS'(iir_next >>> MAX_LOG2);
        valid_d = 1'b1;
        blk_d   = blk_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      mode_q  <= MODE_BOX;
      l_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      blk_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      l_q     <= l_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      blk_q   <= blk_d;
    end
  end

  assign bus.out_data    = out_q;
  assign bus.sum_o       = sum_q;
  assign bus.out_valid   = valid_q;
  assign bus.block_cnt_o = blk_q;
endmodule

// File: tb/tb_avg_engine.sv
// Bench for avg_engine: directed scenarios plus a randomized run, all checked
// against an arithmetic model of block means and the IIR recurrence.
module tb_avg_engine;
  localparam int IN_BITS  = 16;
  localparam int OUT_BITS = 16;
  localparam int MAX_LOG2 = 16;
  localparam int L_BITS   = 5;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  avg_engine_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .MAX_LOG2(MAX_LOG2), .L_BITS(L_BITS)) bus ();

  avg_engine #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .MAX_LOG2(MAX_LOG2), .L_BITS(L_BITS)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: running block sum and sample count, IIR state as a real-valued
  // fixed-point number held in a longint.
  longint      m_out, m_sum, m_s, blk_sum;
  int          blk_n, m_l;
  bit          m_mode, m_valid;
  int unsigned m_cnt;

  function automatic void model_step();
    int     len;
    longint x;
    if (!aresetn) begin
      m_out = 0; m_sum = 0; m_s = 0; blk_sum = 0; blk_n = 0; m_l = 0;
      m_mode = 1'b0; m_valid = 1'b0; m_cnt = 0;
      return;
    end
    m_valid = 1'b0;
    if (bus.clear_i || (bus.mode_i != m_mode)) begin
      m_mode = bus.mode_i; blk_sum = 0; blk_n = 0; m_s = 0;
      return;
    end
    if (!bus.in_valid) return;
    len = int'(bus.log2_len_i);
    if (len > MAX_LOG2) len = MAX_LOG2;
    x = longint'(bus.in_data);
    if (!m_mode) begin
      if (blk_n == 0) m_l = len;
      blk_sum += x;
      blk_n++;
      if (blk_n == (1 << m_l)) begin
        m_sum = blk_sum;
        m_out = blk_sum >>> m_l;
        m_valid = 1'b1;
        m_cnt++;
        blk_sum = 0;
        blk_n = 0;
      end
    end else begin
      m_s = m_s + (((x * 65536) - m_s) >>> len);
      m_out = m_s >>> MAX_LOG2;
      m_valid = 1'b1;
      m_cnt++;
    end
  endfunction

  task automatic drive(input bit mode, input int len, input bit clr, input bit vld, input int data);
    bus.mode_i     = mode;
    bus.log2_len_i = L_BITS'(len);
    bus.clear_i    = clr;
    bus.in_valid   = vld;
    bus.in_data    = IN_BITS'(data);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive(1'b1, 3, 1'b0, 1'b1, 5);
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out got=%0d exp=0", bus.out_data); end
    total++; if (bus.sum_o !== '0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", bus.sum_o); end
    total++; if (bus.block_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.block_cnt_o); end
    aresetn = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    tick();
  endtask

  task automatic test_box_basic();
    int samples[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2, 1'b0, 1'b1, samples[i]);
      tick();
      if (i < 3) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL box_early_valid i=%0d got=1 exp=0", i); end
      end
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL box_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.sum_o !== 32'sd100) begin bad++; $display("FAIL box_sum got=%0d exp=100", bus.sum_o); end
    total++; if (bus.out_data !== 16'sd25) begin bad++; $display("FAIL box_out got=%0d exp=25", bus.out_data); end
    total++; if (bus.block_cnt_o !== 32'd1) begin bad++; $display("FAIL box_cnt got=%0d exp=1", bus.block_cnt_o); end
    drive(1'b0, 2, 1'b0, 1'b0, 0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL box_pulse got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'sd25) begin bad++; $display("FAIL box_hold got=%0d exp=25", bus.out_data); end
  endtask

  task automatic test_box_floor_midchange();
    drive(1'b0, 1, 1'b0, 1'b1, -3); tick();
    drive(1'b0, 1, 1'b0, 1'b1, -2); tick();
    total++; if (bus.sum_o !== -32'sd5) begin bad++; $display("FAIL floor_sum got=%0d exp=-5", bus.sum_o); end
    total++; if (bus.out_data !== -16'sd3) begin bad++; $display("FAIL floor_out got=%0d exp=-3", bus.out_data); end
    drive(1'b0, 1, 1'b0, 1'b1, 5); tick();
    drive(1'b0, 3, 1'b0, 1'b1, 6); tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midchg_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.sum_o !== 32'sd11 || bus.out_data !== 16'sd5) begin
      bad++; $display("FAIL midchg_block got sum=%0d out=%0d exp sum=11 out=5", bus.sum_o, bus.out_data);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 3, 1'b0, 1'b1, i); tick();
      total++; if (bus.out_valid !== (i == 8)) begin bad++; $display("FAIL len8_valid i=%0d got=%0b exp=%0b", i, bus.out_valid, i == 8); end
    end
    total++; if (bus.sum_o !== 32'sd36 || bus.out_data !== 16'sd4) begin
      bad++; $display("FAIL len8_block got sum=%0d out=%0d exp sum=36 out=4", bus.sum_o, bus.out_data);
    end
    total++; if (bus.block_cnt_o !== 32'd4) begin bad++; $display("FAIL len8_cnt got=%0d exp=4", bus.block_cnt_o); end
  endtask

  task automatic test_clamp();
    int early = 0;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b0, 20, 1'b0, 1'b1, -32768);
      tick();
      if (i < 65535 && bus.out_valid) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL clamp_early got=%0d exp=0", early); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL clamp_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.sum_o !== -32'sd2147483648) begin bad++; $display("FAIL clamp_sum got=%0d exp=-2147483648", bus.sum_o); end
    total++; if (bus.out_data !== -16'sd32768) begin bad++; $display("FAIL clamp_out got=%0d exp=-32768", bus.out_data); end
  endtask

  task automatic test_iir_step();
    int exp3[3] = '{250, 437, 578};
    int prev;
    drive(1'b1, 0, 1'b0, 1'b1, 99); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL iir_switch_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== -16'sd32768) begin bad++; $display("FAIL iir_switch_hold got=%0d exp=-32768", bus.out_data); end
    drive(1'b1, 0, 1'b0, 1'b1, 1000); tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd1000) begin
      bad++; $display("FAIL iir_l0 got valid=%0b out=%0d exp valid=1 out=1000", bus.out_valid, bus.out_data);
    end
    drive(1'b1, 0, 1'b0, 1'b1, 0); tick();
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 2, 1'b0, 1'b1, 1000); tick();
      if (i < 3) begin
        total++; if (int'(bus.out_data) != exp3[i]) begin bad++; $display("FAIL iir_l2 i=%0d got=%0d exp=%0d", i, bus.out_data, exp3[i]); end
      end
      total++; if (longint'(bus.out_data) != m_out) begin bad++; $display("FAIL iir_model i=%0d got=%0d exp=%0d", i, bus.out_data, m_out); end
      total++; if (int'(bus.out_data) < prev || int'(bus.out_data) > 1000) begin
        bad++; $display("FAIL iir_mono i=%0d got=%0d prev=%0d limit=1000", i, bus.out_data, prev);
      end
      prev = int'(bus.out_data);
    end
    total++; if (prev < 990) begin bad++; $display("FAIL iir_converge got=%0d exp>=990", prev); end
  endtask

  task automatic test_clear();
    aresetn = 1'b0; drive(1'b0, 2, 1'b0, 1'b0, 0); tick();
    aresetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 2, (i >= 3), 1'b1, i); tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clear_valid i=%0d got=1 exp=0", i); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2, 1'b0, 1'b1, 8); tick();
    end
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd8) begin
      bad++; $display("FAIL clear_next got valid=%0b out=%0d exp valid=1 out=8", bus.out_valid, bus.out_data);
    end
    total++; if (bus.block_cnt_o !== 32'd1) begin bad++; $display("FAIL clear_cnt got=%0d exp=1", bus.block_cnt_o); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2, 1'b0, 1'b1, 3); tick();
    drive(1'b0, 2, 1'b0, 1'b1, 4); tick();
    aresetn = 1'b0;
    drive(1'b0, 2, 1'b0, 1'b1, 100); tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.sum_o !== '0 || bus.block_cnt_o !== '0) begin
      bad++; $display("FAIL rstmid got valid=%0b out=%0d sum=%0d cnt=%0d exp all 0",
                      bus.out_valid, bus.out_data, bus.sum_o, bus.block_cnt_o);
    end
    aresetn = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b1, 7); tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd7) begin
      bad++; $display("FAIL rstmid_l0 got valid=%0b out=%0d exp valid=1 out=7", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_random();
    bit mode = 1'b0;
    int len;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
      aresetn = ($urandom_range(0, 499) != 0);
      drive(mode, len, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)));
      tick();
      if (!aresetn) mode = 1'b0;
      total++; if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_valid); end
      total++; if (longint'(bus.out_data) != m_out) begin bad++; $display("FAIL rnd_out c=%0d got=%0d exp=%0d", c, bus.out_data, m_out); end
      total++; if (longint'(bus.sum_o) != m_sum) begin bad++; $display("FAIL rnd_sum c=%0d got=%0d exp=%0d", c, bus.sum_o, m_sum); end
      total++; if (bus.block_cnt_o !== 32'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.block_cnt_o, m_cnt); end
    end
    aresetn = 1'b1;
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    test_reset();
    test_box_basic();
    test_box_floor_midchange();
    test_clamp();
    test_iir_step();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
